// File: rtl/mips_pkg.sv
// Shared widths and the buffered MDU entry type for the register writeback path.
package mips_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int WB_DEPTH   = 2;
    localparam int WB_CNT_W   = $clog2(WB_DEPTH + 1);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
        logic                  killed;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Small in-order FIFO of MDU results with kill-by-address; entry 0 is always the head.
module wb_fifo
    import mips_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  wb_entry_t                        push_entry,
    input  logic                             pop,
    input  logic                             kill_en,
    input  logic [REG_ADDR_W-1:0]            kill_addr,
    output logic                             full,
    output logic                             empty,
    output wb_entry_t                        head,
    output wb_entry_t [WB_DEPTH-1:0]         peek,
    output logic [WB_DEPTH-1:0]              peek_valid
);
    wb_entry_t [WB_DEPTH-1:0] entry_q, entry_d;
    logic [WB_CNT_W-1:0]      count_q, count_d;
    logic                     do_pop;
    logic                     do_push;

    assign full  = (count_q == WB_CNT_W'(WB_DEPTH));
    assign empty = (count_q == '0);
    assign head  = entry_q[0];
    assign peek  = entry_q;

    always_comb begin
        for (int i = 0; i < WB_DEPTH; i++) begin
            peek_valid[i] = (WB_CNT_W'(i) < count_q);
        end
    end

    always_comb begin
        entry_d = entry_q;
        count_d = count_q;
        do_pop  = pop && !empty;
        do_push = push && !full;
        if (do_pop) begin
            for (int i = 0; i < WB_DEPTH - 1; i++) begin
                entry_d[i] = entry_q[i+1];
            end
            entry_d[WB_DEPTH-1] = '0;
            count_d = count_q - 1'b1;
        end
        if (do_push) begin
            for (int i = 0; i < WB_DEPTH; i++) begin
                if (count_d == WB_CNT_W'(i)) begin
                    entry_d[i] = push_entry;
                end
            end
            count_d = count_d + 1'b1;
        end
        // Kill is applied after the shift/insert so a same-cycle push is covered too.
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (kill_en && (WB_CNT_W'(i) < count_d) && (entry_d[i].addr == kill_addr)) begin
                entry_d[i].killed = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= '0;
            count_q <= '0;
        end else begin
            entry_q <= entry_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/reg_writeback.sv
// Register-file write port arbiter: ALU results win, MDU results wait in a
// small FIFO and drain in idle ALU cycles; a newer ALU write kills stale MDU entries.
module reg_writeback
    import mips_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  mdu_valid,
    output logic                  mdu_ready,
    input  logic [REG_ADDR_W-1:0] mdu_addr,
    input  logic [DATA_W-1:0]     mdu_data,
    output logic                  wr,
    output logic [REG_ADDR_W-1:0] addr3,
    output logic [DATA_W-1:0]     data3,
    output logic [DATA_W-1:0]     pend_mask
);
    logic                     wr_q, wr_d;
    logic [REG_ADDR_W-1:0]    addr3_q, addr3_d;
    logic [DATA_W-1:0]        data3_q, data3_d;

    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_pop;
    logic                     fifo_push;
    logic                     kill_en;
    wb_entry_t                push_entry;
    wb_entry_t                fifo_head;
    wb_entry_t [WB_DEPTH-1:0] fifo_peek;
    logic [WB_DEPTH-1:0]      fifo_peek_valid;

    assign mdu_ready  = !rst && !fifo_full;
    assign fifo_push  = mdu_valid && mdu_ready;
    assign kill_en    = alu_valid && (alu_addr != '0);
    assign push_entry = '{addr: mdu_addr, data: mdu_data, killed: 1'b0};

    wb_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .kill_en    (kill_en),
        .kill_addr  (alu_addr),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (fifo_head),
        .peek       (fifo_peek),
        .peek_valid (fifo_peek_valid)
    );

    always_comb begin
        wr_d     = 1'b0;
        addr3_d  = addr3_q;
        data3_d  = data3_q;
        fifo_pop = 1'b0;
        if (alu_valid) begin
            wr_d    = (alu_addr != '0);
            addr3_d = alu_addr;
            data3_d = alu_data;
        end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            wr_d     = (fifo_head.addr != '0) && !fifo_head.killed;
            addr3_d  = fifo_head.addr;
            data3_d  = fifo_head.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= 1'b0;
            addr3_q <= '0;
            data3_q <= '0;
        end else begin
            wr_q    <= wr_d;
            addr3_q <= addr3_d;
            data3_q <= data3_d;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (fifo_peek_valid[i] && !fifo_peek[i].killed) begin
                pend_mask[fifo_peek[i].addr] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
    end

    assign wr    = wr_q;
    assign addr3 = addr3_q;
    assign data3 = data3_q;
endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: ALU path, MDU buffering, backpressure, WAW kill, r0 and reset.
module tb_reg_writeback;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic        wr;
    logic [4:0]  addr3;
    logic [31:0] data3;
    logic [31:0] pend_mask;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    reg_writeback dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .mdu_valid (mdu_valid),
        .mdu_ready (mdu_ready),
        .mdu_addr  (mdu_addr),
        .mdu_data  (mdu_data),
        .wr        (wr),
        .addr3     (addr3),
        .data3     (data3),
        .pend_mask (pend_mask)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic v, input logic [4:0] a, input logic [31:0] d);
        alu_valid = v; alu_addr = a; alu_data = d;
    endtask

    task automatic mdu(input logic v, input logic [4:0] a, input logic [31:0] d);
        mdu_valid = v; mdu_addr = a; mdu_data = d;
    endtask

    task automatic check_wb(input string tag, input logic w, input logic [4:0] a, input logic [31:0] d);
        check({tag, "_wr"}, {31'd0, wr}, {31'd0, w});
        check({tag, "_addr3"}, {27'd0, addr3}, {27'd0, a});
        check({tag, "_data3"}, data3, d);
    endtask

    initial begin
        rst = 1'b1;
        alu(1'b0, 5'd0, 32'h0);
        mdu(1'b0, 5'd0, 32'h0);
        tick();
        tick();
        check_wb("reset", 1'b0, 5'd0, 32'h0);
        check("reset_ready", {31'd0, mdu_ready}, 32'd0);
        check("reset_pend", pend_mask, 32'h0);
        rst = 1'b0;
        #1;
        check("post_reset_ready", {31'd0, mdu_ready}, 32'd1);

        // ALU only, then idle hold
        alu(1'b1, 5'd10, 32'h0000_FFFF);
        tick();
        check_wb("alu", 1'b1, 5'd10, 32'h0000_FFFF);
        alu(1'b0, 5'd0, 32'h0);
        tick();
        check_wb("idle_hold", 1'b0, 5'd10, 32'h0000_FFFF);

        // MDU uncontended
        mdu(1'b1, 5'd14, 32'h0000_FF00);
        check("mdu_ready_empty", {31'd0, mdu_ready}, 32'd1);
        tick();
        mdu(1'b0, 5'd0, 32'h0);
        check("mdu_pend_n1", pend_mask, 32'h0000_4000);
        check("mdu_wr_n1", {31'd0, wr}, 32'd0);
        tick();
        check_wb("mdu_n2", 1'b1, 5'd14, 32'h0000_FF00);
        check("mdu_pend_n2", pend_mask, 32'h0);

        // Backpressure: ALU busy for four cycles
        alu(1'b1, 5'd20, 32'h2020_2020);
        mdu(1'b1, 5'd3, 32'h0000_0033);
        check("bp_ready_c1", {31'd0, mdu_ready}, 32'd1);
        tick();
        check_wb("bp_alu_c1", 1'b1, 5'd20, 32'h2020_2020);
        alu(1'b1, 5'd21, 32'h2121_2121);
        mdu(1'b1, 5'd4, 32'h0000_0044);
        check("bp_ready_c2", {31'd0, mdu_ready}, 32'd1);
        tick();
        check_wb("bp_alu_c2", 1'b1, 5'd21, 32'h2121_2121);
        alu(1'b1, 5'd22, 32'h2222_2222);
        mdu(1'b1, 5'd5, 32'h0000_0055);
        check("bp_ready_c3", {31'd0, mdu_ready}, 32'd0);
        tick();
        check_wb("bp_alu_c3", 1'b1, 5'd22, 32'h2222_2222);
        alu(1'b1, 5'd23, 32'h2323_2323);
        check("bp_ready_c4", {31'd0, mdu_ready}, 32'd0);
        tick();
        check_wb("bp_alu_c4", 1'b1, 5'd23, 32'h2323_2323);
        alu(1'b0, 5'd0, 32'h0);
        mdu(1'b0, 5'd0, 32'h0);
        check("bp_pend", pend_mask, 32'h0000_0018);
        tick();
        check_wb("bp_drain3", 1'b1, 5'd3, 32'h0000_0033);
        check("bp_pend_after3", pend_mask, 32'h0000_0010);
        tick();
        check_wb("bp_drain4", 1'b1, 5'd4, 32'h0000_0044);
        tick();
        check("bp_empty_wr", {31'd0, wr}, 32'd0);
        check("bp_empty_pend", pend_mask, 32'h0);

        // WAW kill of a buffered entry
        mdu(1'b1, 5'd31, 32'h0000_1234);
        tick();
        mdu(1'b0, 5'd0, 32'h0);
        check("waw_pend_before", pend_mask, 32'h8000_0000);
        alu(1'b1, 5'd31, 32'h0000_AAAA);
        tick();
        check_wb("waw_alu", 1'b1, 5'd31, 32'h0000_AAAA);
        check("waw_pend_after", pend_mask, 32'h0);
        alu(1'b0, 5'd0, 32'h0);
        tick();
        check("waw_killed_wr", {31'd0, wr}, 32'd0);
        check("waw_ready", {31'd0, mdu_ready}, 32'd1);

        // WAW kill of an entry enqueued in the same cycle
        alu(1'b1, 5'd7, 32'h0000_7777);
        mdu(1'b1, 5'd7, 32'h0000_0707);
        tick();
        check_wb("waw_same_alu", 1'b1, 5'd7, 32'h0000_7777);
        check("waw_same_pend", pend_mask, 32'h0);
        alu(1'b0, 5'd0, 32'h0);
        mdu(1'b0, 5'd0, 32'h0);
        tick();
        check("waw_same_drain_wr", {31'd0, wr}, 32'd0);
        tick();
        check("waw_same_idle_wr", {31'd0, wr}, 32'd0);

        // Register 0 writes are suppressed
        alu(1'b1, 5'd0, 32'h0000_0005);
        tick();
        check_wb("r0_alu", 1'b0, 5'd0, 32'h0000_0005);
        alu(1'b0, 5'd0, 32'h0);
        mdu(1'b1, 5'd0, 32'h0000_0006);
        tick();
        mdu(1'b0, 5'd0, 32'h0);
        check("r0_mdu_pend", pend_mask, 32'h0);
        check("r0_mdu_wr_n1", {31'd0, wr}, 32'd0);
        tick();
        check("r0_mdu_drain_wr", {31'd0, wr}, 32'd0);
        check("r0_mdu_pend_n2", pend_mask, 32'h0);

        // Reset with the FIFO full discards both entries
        alu(1'b1, 5'd9, 32'h0000_0009);
        mdu(1'b1, 5'd1, 32'h0000_0011);
        tick();
        mdu(1'b1, 5'd2, 32'h0000_0022);
        tick();
        check("rst_full_pend", pend_mask, 32'h0000_0006);
        check("rst_full_ready", {31'd0, mdu_ready}, 32'd0);
        alu(1'b0, 5'd0, 32'h0);
        mdu(1'b0, 5'd0, 32'h0);
        rst = 1'b1;
        tick();
        check_wb("rst_mid", 1'b0, 5'd0, 32'h0);
        check("rst_mid_ready", {31'd0, mdu_ready}, 32'd0);
        check("rst_mid_pend", pend_mask, 32'h0);
        rst = 1'b0;
        #1;
        check("rst_after_ready", {31'd0, mdu_ready}, 32'd1);
        tick();
        check_wb("rst_after_c1", 1'b0, 5'd0, 32'h0);
        tick();
        check_wb("rst_after_c2", 1'b0, 5'd0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, exactly as decided: clk rising-edge only; rst sampled on clk, high = reset.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 alu_valid  input  1  single-cycle ALU result present this cycle; never stalled.
REQ-005 alu_addr  input  5  ALU destination register.
REQ-006 alu_data  input  32  ALU result.
REQ-007 mdu_valid  input  1  multiply/divide result offered.
REQ-008 mdu_ready  output  1  block accepts the MDU result this cycle.
REQ-009 mdu_addr  input  5  MDU destination register.
REQ-010 mdu_data  input  32  MDU result.
REQ-011 wr  output  1  register-file write enable.
REQ-012 addr3  output  5  register-file write address.
REQ-013 data3  output  32  register-file write data.
REQ-014 pend_mask  output  32  bit i high while a live buffered MDU entry targets register i.

Function
REQ-015 Each cycle, at most one register write SHALL be issued; wr, addr3 and data3 SHALL be registered outputs.
REQ-016 ALU priority: alu_valid in cycle N SHALL produce wr=1, addr3=alu_addr, data3=alu_data in cycle N+1.
REQ-017 Writes to register 0 SHALL be suppressed: wr=0, with addr3/data3 still updated.
REQ-018 MDU results SHALL enter a 2-entry FIFO on mdu_valid && mdu_ready; mdu_ready = (count < 2), from registered count only, with no same-cycle bypass.
REQ-019 The FIFO head SHALL drain only in a cycle with alu_valid=0, producing the write in the next cycle; uncontended MDU latency = 2 cycles from acceptance.
REQ-020 Enqueue and drain in the same cycle SHALL leave count unchanged; entry order SHALL be strictly FIFO.
REQ-021 WAW kill: alu_valid with nonzero alu_addr equal to a buffered entry's addr SHALL mark that entry killed; this includes an entry enqueued in the same cycle.
REQ-022 A killed entry SHALL still drain in order, consuming its slot, with wr=0 for that cycle.
REQ-023 pend_mask SHALL be combinational from live (not killed) FIFO entries; register 0 bit always 0.
REQ-024 No FIFO activity and alu_valid=0 SHALL produce wr=0, with addr3/data3 holding their previous values.

Reset
REQ-025 While rst=1: wr=0, addr3=0, data3=0, FIFO count=0, all kill flags cleared, mdu_ready=0.
REQ-026 Reset mid-operation SHALL discard buffered MDU entries without writing them; mdu_ready SHALL return to 1 in the first cycle after rst deasserts.

Structure
REQ-027 Shared package mips_pkg SHALL hold REG_ADDR_W=5, DATA_W=32, WB_DEPTH=2 and the FIFO entry struct {addr, data, killed}.
REQ-028 The FIFO SHALL be one sub-module, wb_fifo (push, pop, kill-by-address, full/empty, per-entry peek for pend_mask).

Verification
REQ-029 ALU only: alu_valid=1, alu_addr=10, alu_data=0000FFFF -> next cycle wr=1, addr3=10, data3=0000FFFF.
REQ-030 MDU uncontended: mdu_valid=1, addr=14, data=0000FF00 at cycle N -> pend_mask[14]=1 in N+1; write in N+2; pend_mask[14]=0 in N+2.
REQ-031 Backpressure: alu_valid held 1 for 4 cycles; two MDU offers (addr 3, 4) accepted -> mdu_ready=0 in cycles 3-4; after ALU stops, writes to 3 then 4 on consecutive cycles.
REQ-032 WAW kill: MDU addr 31 buffered, then alu_valid addr 31 data AAAA -> ALU write 31=AAAA; the drained MDU entry shows wr=0; pend_mask[31] clears the cycle after kill.
REQ-033 Register 0: alu_addr=0 or mdu_addr=0 -> wr never 1; pend_mask[0] stays 0.
REQ-034 Reset mid-operation: FIFO full (addrs 1, 2), rst=1 for one cycle -> no writes to 1 or 2; mdu_ready=1 in the first cycle after reset; outputs zero during reset.
